// File: rtl/alu_issue_pkg.sv
// Shared types and field layout for the ALU issue block: FSM states,
// command record and select-field bit positions.
package alu_issue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int unsigned A_W   = 4;
    localparam int unsigned B_W   = 4;
    localparam int unsigned SEL_W = 5;
    localparam int unsigned TAG_W = 2;
    localparam int unsigned Y_W   = 8;
    localparam int unsigned CMD_W = A_W + B_W + SEL_W + TAG_W;

    localparam int unsigned SEL_OP_LSB    = 0;
    localparam int unsigned SEL_OP_MSB    = 2;
    localparam int unsigned SEL_ARITH_BIT = 3;
    localparam int unsigned SEL_ERR_BIT   = 4;

    typedef struct packed {
        logic [A_W-1:0]   a;
        logic [B_W-1:0]   b;
        logic [SEL_W-1:0] sel;
        logic [TAG_W-1:0] tag;
    } cmd_t;

endpackage

// File: rtl/alu_issue_if.sv
// Command, ALU and result signals of alu_issue; slave is the block side,
// master is the producer/ALU/consumer side.
interface alu_issue_if;
    import alu_issue_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [A_W-1:0]   in_a;
    logic [B_W-1:0]   in_b;
    logic [SEL_W-1:0] in_sel;

    logic [A_W-1:0]   alu_a;
    logic [B_W-1:0]   alu_b;
    logic [SEL_W-1:0] alu_sel;
    logic [Y_W-1:0]   alu_y;

    logic             out_valid;
    logic             out_ready;
    logic [Y_W-1:0]   out_y;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;
    logic             out_neg;
    logic             out_err;

    modport slave (
        input  in_valid, in_a, in_b, in_sel, alu_y, out_ready,
        output in_ready, alu_a, alu_b, alu_sel,
               out_valid, out_y, out_tag, out_zero, out_neg, out_err
    );

    modport master (
        output in_valid, in_a, in_b, in_sel, alu_y, out_ready,
        input  in_ready, alu_a, alu_b, alu_sel,
               out_valid, out_y, out_tag, out_zero, out_neg, out_err
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Command queue for alu_issue: power-of-two depth, occupancy 0..DEPTH,
// show-ahead head output.
module alu_cmd_fifo
    import alu_issue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_push,
    input  logic i_pop,
    input  cmd_t i_data,
    output cmd_t o_data,
    output logic o_full,
    output logic o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    cmd_t             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Issues queued commands to an external combinational ALU and holds each
// tagged result until the consumer takes it.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input logic        clk,
    input logic        rst_n,
    alu_issue_if.slave bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    cmd_t             w_push_cmd;
    cmd_t             w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_capture;
    logic             w_release;

    logic [TAG_W-1:0] r_tag_cnt;
    logic [TAG_W-1:0] r_tag_pend;
    logic             r_err_pend;
    logic [A_W-1:0]   r_alu_a;
    logic [B_W-1:0]   r_alu_b;
    logic [SEL_W-1:0] r_alu_sel;
    logic             r_out_valid;
    logic [Y_W-1:0]   r_out_y;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_out_zero;
    logic             r_out_neg;
    logic             r_out_err;

    assign w_push        = bus.in_valid && !w_full;
    assign bus.in_ready  = !w_full;
    assign w_push_cmd    = '{a: bus.in_a, b: bus.in_b, sel: bus.in_sel, tag: r_tag_cnt};

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_push_cmd),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_capture   = 1'b1;
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    w_release   = 1'b1;
                    w_pop       = !w_empty;
                    w_state_nxt = w_empty ? ST_IDLE : ST_EXEC;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_tag_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) r_tag_cnt <= r_tag_cnt + 1'b1;
        end
    end

    // Reserved select bit is stripped before reaching the ALU and travels as err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_sel  <= '0;
            r_tag_pend <= '0;
            r_err_pend <= 1'b0;
        end else if (w_pop) begin
            r_alu_a    <= w_head.a;
            r_alu_b    <= w_head.b;
            r_alu_sel  <= {1'b0, w_head.sel[SEL_ARITH_BIT:SEL_OP_LSB]};
            r_tag_pend <= w_head.tag;
            r_err_pend <= w_head.sel[SEL_ERR_BIT];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_y     <= '0;
            r_out_tag   <= '0;
            r_out_zero  <= 1'b0;
            r_out_neg   <= 1'b0;
            r_out_err   <= 1'b0;
        end else if (w_capture) begin
            r_out_valid <= 1'b1;
            r_out_y     <= r_err_pend ? '0 : bus.alu_y;
            r_out_tag   <= r_tag_pend;
            r_out_zero  <= r_err_pend || (bus.alu_y == '0);
            r_out_neg   <= !r_err_pend && bus.alu_y[Y_W-1];
            r_out_err   <= r_err_pend;
        end else if (w_release) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_sel   = r_alu_sel;
    assign bus.out_valid = r_out_valid;
    assign bus.out_y     = r_out_y;
    assign bus.out_tag   = r_out_tag;
    assign bus.out_zero  = r_out_zero;
    assign bus.out_neg   = r_out_neg;
    assign bus.out_err   = r_out_err;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: reference ALU on the alu_* port, directed vector
// table, back-pressure/reset sequences and a randomised ordered scoreboard.
module tb_alu_issue;
    import alu_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    alu_issue_if bus();

    alu_issue #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference ALU: arith add/sub/mul, logic and/or/xor/not.
    function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [4:0] sel);
        logic signed [7:0] sa;
        logic signed [7:0] sb;
        logic [2:0]        op;
        sa = {{4{a[3]}}, a};
        sb = {{4{b[3]}}, b};
        op = sel[SEL_OP_MSB:SEL_OP_LSB];
        if (sel[SEL_ARITH_BIT]) begin
            case (op)
                3'd0:    return sa & sb;
                3'd1:    return sa | sb;
                3'd2:    return sa ^ sb;
                default: return ~sa;
            endcase
        end else begin
            case (op)
                3'd0:    return sa + sb;
                3'd1:    return sa - sb;
                3'd7:    return sa * sb;
                default: return sa;
            endcase
        end
    endfunction

    assign bus.alu_y = alu_f(bus.alu_a, bus.alu_b, bus.alu_sel);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [3:0] a, input logic [3:0] b, input logic [4:0] sel);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sel   = sel;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] sel;
        logic [7:0] y;
        logic       zero;
        logic       neg;
        logic       err;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [12:0] q[$];
        logic [12:0] exp_rec;
        logic [7:0]  ey;
        int unsigned acc;
        int unsigned got;
        int unsigned tagcnt;

        vecs[0] = '{4'h3, 4'h4, 5'b00000, 8'h07, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{4'hD, 4'h5, 5'b00111, 8'hF1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{4'h2, 4'h2, 5'b00001, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{4'h7, 4'h7, 5'b10000, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{4'h5, 4'h3, 5'b00000, 8'h08, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{4'h8, 4'h8, 5'b00111, 8'h40, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{4'hC, 4'h3, 5'b01001, 8'hFF, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{4'h5, 4'h3, 5'b01010, 8'h06, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{4'h8, 4'h7, 5'b00001, 8'hF1, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{4'hA, 4'hB, 5'b11111, 8'h00, 1'b1, 1'b0, 1'b1};

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sel    = '0;
        bus.out_ready = 1'b0;

        #2;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_outs", 32'({bus.out_valid, bus.out_y, bus.out_tag, bus.out_zero, bus.out_neg,
                              bus.out_err, bus.alu_a, bus.alu_b, bus.alu_sel}), 32'd0);
        do_reset();

        // Directed vectors, one at a time, consumer always ready.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_one(vecs[i].a, vecs[i].b, vecs[i].sel);
            @(posedge clk); #1;
            chk("vec_lat_early", 32'(bus.out_valid), 32'd0);
            @(posedge clk); #1;
            chk("vec_lat_valid", 32'(bus.out_valid), 32'd1);
            chk("vec_y", 32'(bus.out_y), 32'(vecs[i].y));
            chk("vec_flags", 32'({bus.out_zero, bus.out_neg, bus.out_err}),
                32'({vecs[i].zero, vecs[i].neg, vecs[i].err}));
            chk("vec_tag", 32'(bus.out_tag), 32'(i % 4));
            chk("vec_alu_ops", 32'({bus.alu_a, bus.alu_b}), 32'({vecs[i].a, vecs[i].b}));
            chk("vec_alu_sel", 32'(bus.alu_sel), 32'({1'b0, vecs[i].sel[3:0]}));
            @(posedge clk); #1;
            chk("vec_release", 32'(bus.out_valid), 32'd0);
        end

        // Back-pressure: 8 offers against a stalled consumer.
        do_reset();
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 4'(i);
            bus.in_b     = 4'h1;
            bus.in_sel   = 5'b00000;
            if (bus.in_ready) acc++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        chk("bp_accepted", acc, 32'd5);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.out_valid) begin
                chk("bp_y", 32'(bus.out_y), got + 1);
                chk("bp_tag", 32'(bus.out_tag), got % 4);
                got++;
            end
            @(posedge clk); #1;
        end
        chk("bp_count", got, 32'd5);

        // Reset while holding a result with three more queued.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 4'(i + 1);
            bus.in_b     = 4'h2;
            bus.in_sel   = 5'b00000;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        chk("hr_holding", 32'(bus.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("hr_in_ready", 32'(bus.in_ready), 32'd1);
        chk("hr_outs", 32'({bus.out_valid, bus.out_y, bus.out_tag, bus.out_zero, bus.out_neg,
                             bus.out_err, bus.alu_a, bus.alu_b, bus.alu_sel}), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        got = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.out_valid) got++;
        end
        chk("hr_no_stale", got, 32'd0);
        push_one(4'h1, 4'h1, 5'b00000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("hr_resume_valid", 32'(bus.out_valid), 32'd1);
        chk("hr_resume", 32'({bus.out_tag, bus.out_y}), 32'({2'd0, 8'h02}));

        // Random traffic against an ordered scoreboard.
        do_reset();
        tagcnt = 0;
        got = 0;
        acc = 0;
        for (int c = 0; c < 1040; c++) begin
            if (c < 1000) begin
                bus.in_valid  = 1'($urandom_range(0, 1));
                bus.in_a      = 4'($urandom);
                bus.in_b      = 4'($urandom);
                bus.in_sel    = 5'($urandom);
                if ($urandom_range(0, 7) != 0) bus.in_sel[4] = 1'b0;
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                bus.in_valid  = 1'b0;
                bus.out_ready = 1'b1;
            end
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                if (bus.in_sel[4]) begin
                    exp_rec = {1'b1, 1'b1, 1'b0, 2'(tagcnt), 8'h00};
                end else begin
                    ey = alu_f(bus.in_a, bus.in_b, {1'b0, bus.in_sel[3:0]});
                    exp_rec = {1'b0, (ey == 8'h00), ey[7], 2'(tagcnt), ey};
                end
                q.push_back(exp_rec);
                tagcnt++;
                acc++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_extra", 32'd1, 32'd0);
                end else begin
                    chk("rnd_result", 32'({bus.out_err, bus.out_zero, bus.out_neg,
                                           bus.out_tag, bus.out_y}), 32'(q.pop_front()));
                end
                got++;
            end
            @(posedge clk); #1;
        end
        chk("rnd_drained", 32'(q.size()), 32'd0);
        chk("rnd_count", got, acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
